cmd_parser: RTL and testbench



---
 rtl/cmd_parser.sv | 151 +++++++++++++++
 tb/tb_cmd_parser.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// Byte-stream command parser: assembles a header plus 0-4 operand bytes
// into one parallel command, classifies it and flags illegal headers.
module cmd_parser #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_class,
    output logic [5:0]       cmd_op,
    output logic [2:0]       cmd_len,
    output logic [31:0]      cmd_args,
    output logic             err_valid,
    output logic [7:0]       err_hdr,
    output logic [CNT_W-1:0] cmd_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] hdr_len;
    logic [2:0] remaining;
    logic [1:0] widx;
    logic       hdr_fire;
    logic       hdr_legal;
    logic       byte_fire;
    logic       cmd_fire;

    // Total length for a header byte; zero marks an illegal class/op pair.
    function automatic logic [2:0] len_of(input logic [7:0] hdr);
        logic [2:0] len;
        case (hdr)
            8'h00:          len = 3'd1;
            8'h01, 8'h02:   len = 3'd3;
            8'h40:          len = 3'd1;
            8'h41, 8'h42:   len = 3'd4;
            8'h43:          len = 3'd5;
            default:        len = 3'd0;
        endcase
        return len;
    endfunction

    assign hdr_len   = len_of(in_data);
    assign hdr_legal = (hdr_len != 3'd0);
    assign hdr_fire  = (state == IDLE) && in_valid;
    assign byte_fire = (state == COLLECT) && in_valid;
    assign cmd_fire  = (state == HOLD) && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        cmd_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hdr_fire && hdr_legal) begin
                    if (hdr_len == 3'd1) begin
                        state_next = HOLD;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (byte_fire && remaining == 3'd1) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                in_ready  = 1'b0;
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command bundle; frozen while HOLD waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_class <= 2'd0;
            cmd_op    <= 6'd0;
            cmd_len   <= 3'd0;
            cmd_args  <= 32'd0;
            remaining <= 3'd0;
            widx      <= 2'd0;
        end else if (hdr_fire && hdr_legal) begin
            cmd_class <= in_data[7:6];
            cmd_op    <= in_data[5:0];
            cmd_len   <= hdr_len;
            cmd_args  <= 32'd0;
            remaining <= hdr_len - 3'd1;
            widx      <= 2'd0;
        end else if (byte_fire) begin
            case (widx)
                2'd0:    cmd_args[31:24] <= in_data;
                2'd1:    cmd_args[23:16] <= in_data;
                2'd2:    cmd_args[15:8]  <= in_data;
                default: cmd_args[7:0]   <= in_data;
            endcase
            remaining <= remaining - 3'd1;
            widx      <= widx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_hdr   <= 8'd0;
            err_count <= 8'd0;
        end else begin
            err_valid <= hdr_fire && !hdr_legal;
            if (hdr_fire && !hdr_legal) begin
                err_hdr <= in_data;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count <= '0;
        end else if (cmd_fire) begin
            cmd_count <= cmd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: expected commands and error headers are
// queued as bytes are driven and compared when the parser emits them.
module tb_cmd_parser;

    typedef struct packed {
        logic [1:0]  cls;
        logic [5:0]  op;
        logic [2:0]  len;
        logic [31:0] args;
    } exp_cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_class;
    logic [5:0]  cmd_op;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_args;
    logic        err_valid;
    logic [7:0]  err_hdr;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    exp_cmd_t   cmd_q[$];
    logic [7:0] err_q[$];
    int         exp_cnt = 0;
    int         exp_err = 0;

    cmd_parser #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_class (cmd_class),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_args  (cmd_args),
        .err_valid (err_valid),
        .err_hdr   (err_hdr),
        .cmd_count (cmd_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] cls, input logic [5:0] op,
                            input logic [2:0] len, input logic [31:0] args);
        exp_cmd_t c;
        c.cls  = cls;
        c.op   = op;
        c.len  = len;
        c.args = args;
        cmd_q.push_back(c);
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        if (!r) check("send_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt = 0;
            exp_err = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_cmd_t c;
                    c = cmd_q.pop_front();
                    check("cmd_class", {30'd0, cmd_class}, {30'd0, c.cls});
                    check("cmd_op", {26'd0, cmd_op}, {26'd0, c.op});
                    check("cmd_len", {29'd0, cmd_len}, {29'd0, c.len});
                    check("cmd_args", cmd_args, c.args);
                    check("cmd_count_pre", {16'd0, cmd_count}, exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % 65536;
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    check("err_unexpected", 32'd1, 32'd0);
                end else begin
                    check("err_hdr", {24'd0, err_hdr}, {24'd0, err_q.pop_front()});
                end
                if (exp_err < 255) exp_err++;
                check("err_count", {24'd0, err_count}, exp_err);
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b1;
        step(2);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_err_valid", {31'd0, err_valid}, 32'd0);
        check("rst_bundle", {cmd_class, cmd_op, cmd_len}, 32'd0);
        check("rst_args", cmd_args, 32'd0);
        check("rst_err_hdr", {24'd0, err_hdr}, 32'd0);
        check("rst_counts", {8'd0, cmd_count, err_count}, 32'd0);
        step(1);
        rst_n = 1'b1;

        // ADD, consumer ready
        push_cmd(2'd0, 6'd1, 3'd3, 32'h05070000);
        send(8'h01);
        send(8'h05);
        send(8'h07);
        @(negedge clk);
        check("add_latency", {31'd0, cmd_valid}, 32'd1);
        @(negedge clk);
        check("add_one_cycle", {31'd0, cmd_valid}, 32'd0);
        check("add_count", {16'd0, cmd_count}, 32'd1);
        check("add_in_ready", {31'd0, in_ready}, 32'd1);
        step(1);

        // LOAD_RGR with backpressure
        cmd_ready = 1'b0;
        push_cmd(2'd1, 6'd1, 3'd4, 32'h03123400);
        send(8'h41);
        send(8'h03);
        send(8'h12);
        send(8'h34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, cmd_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_args", cmd_args, 32'h03123400);
            check("hold_len", {29'd0, cmd_len}, 32'd4);
        end
        step(1);
        cmd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("load_released", {31'd0, cmd_valid}, 32'd0);
        check("load_count", {16'd0, cmd_count}, 32'd2);
        step(1);

        // COPY with two idle cycles between bytes
        push_cmd(2'd1, 6'd3, 3'd5, 32'hAABBCCDD);
        send(8'h43);
        step(2);
        send(8'hAA);
        step(2);
        send(8'hBB);
        step(2);
        send(8'hCC);
        step(2);
        send(8'hDD);
        step(3);

        // illegal headers followed by NOOP
        err_q.push_back(8'h05);
        err_q.push_back(8'h81);
        push_cmd(2'd0, 6'd0, 3'd1, 32'd0);
        send(8'h05);
        @(negedge clk);
        check("err_pulse", {31'd0, err_valid}, 32'd1);
        step(1);
        send(8'h81);
        send(8'h00);
        step(3);
        @(negedge clk);
        check("err_hdr_final", {24'd0, err_hdr}, 32'h81);
        check("err_count_final", {24'd0, err_count}, 32'd2);
        check("noop_count", {16'd0, cmd_count}, 32'd4);
        step(1);

        // reset in the middle of a SUB
        send(8'h02);
        send(8'h09);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_counts", {8'd0, cmd_count, err_count}, 32'd0);
        check("midrst_args", cmd_args, 32'd0);
        step(1);
        rst_n = 1'b1;
        push_cmd(2'd1, 6'd0, 3'd1, 32'd0);
        send(8'h40);
        @(negedge clk);
        @(negedge clk);
        check("mwait_count", {16'd0, cmd_count}, 32'd1);
        step(1);

        // back-to-back NOOP, header held valid for 10 cycles
        for (int i = 0; i < 5; i++) push_cmd(2'd0, 6'd0, 3'd1, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        step(10);
        in_valid = 1'b0;
        step(2);
        check("b2b_count", {16'd0, cmd_count}, 32'd6);

        // saturate err_count with a stream of illegal headers
        for (int i = 0; i < 260; i++) err_q.push_back(8'hFF);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step(260);
        in_valid = 1'b0;
        step(2);
        check("err_saturate", {24'd0, err_count}, 32'd255);
        check("err_sat_in_ready", {31'd0, in_ready}, 32'd1);

        n = 0;
        while ((cmd_q.size() != 0 || err_q.size() != 0) && n < 20) begin
            step(1);
            n++;
        end
        check("cmd_q_drained", cmd_q.size(), 32'd0);
        check("err_q_drained", err_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
